cpu_seq: RTL



---
 rtl/cpu_seq_pkg.sv | 27 ++
 rtl/seq_perf_cnt.sv | 35 +++
 rtl/cpu_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared definitions for the rvseed multi-cycle sequencer.
//   SEQ_STATE_WIDTH : width of the sequencer state code
//   seq_state_e     : FETCH..HALT encodings (codes 6/7 are illegal)
//   SEQ_TIMEOUT     : default memory handshake timeout in cycles
//   seq_wait_width  : width of the handshake wait counter for a timeout
package cpu_seq_pkg;

    localparam int SEQ_STATE_WIDTH = 3;
    localparam int SEQ_TIMEOUT     = 255;

    typedef enum logic [SEQ_STATE_WIDTH-1:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_EXEC   = 3'd2,
        SEQ_MEM    = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_HALT   = 3'd5
    } seq_state_e;

    // Wait counter must hold TIMEOUT_CYCLES; never narrower than 8 bits.
    function automatic int seq_wait_width(input int t);
        int w;
        w = $clog2(t + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// seq_perf_cnt: retired-instruction and cycle counter pair.
//   clk          : core clock
//   i_clr        : synchronous clear of both counters (wins over enables)
//   i_instret_en : count one retired instruction
//   i_cycle_en   : count one active cycle
//   o_instret    : retired instruction count (wraps silently)
//   o_cycle      : active cycle count (wraps silently)
module seq_perf_cnt #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_instret_en,
    input  logic         i_cycle_en,
    output logic [W-1:0] o_instret,
    output logic [W-1:0] o_cycle
);

    logic [W-1:0] r_instret;
    logic [W-1:0] r_cycle;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_instret <= '0;
            r_cycle   <= '0;
        end else begin
            if (i_instret_en) r_instret <= r_instret + W'(1);
            if (i_cycle_en)   r_cycle   <= r_cycle + W'(1);
        end
    end

    assign o_instret = r_instret;
    assign o_cycle   = r_cycle;

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for rvseed.
//   clk, rst          : core clock, synchronous active-high reset
//   imem_ready        : instruction memory completes the fetch
//   dmem_ready        : data memory completes the access
//   mem_ren, mem_wen  : decoded memory access / store flags
//   reg_wen           : decoded register write enable
//   imem_req          : fetch request
//   dmem_req, dmem_we : data access request and its write qualifier
//   ir_wen, pc_wen    : instruction register / PC write enables
//   rf_wen            : gated register-file write enable
//   busy, bus_err     : core running / sticky handshake timeout
//   state             : current state code (debug)
//   instret, cycle    : retired instructions / active cycles
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       imem_ready,
    input  logic                       dmem_ready,
    input  logic                       mem_ren,
    input  logic                       mem_wen,
    input  logic                       reg_wen,
    output logic                       imem_req,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic                       ir_wen,
    output logic                       pc_wen,
    output logic                       rf_wen,
    output logic                       busy,
    output logic                       bus_err,
    output logic [SEQ_STATE_WIDTH-1:0] state,
    output logic [CNT_WIDTH-1:0]       instret,
    output logic [CNT_WIDTH-1:0]       cycle
);

    localparam int              WC_W   = seq_wait_width(TIMEOUT_CYCLES);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT_CYCLES);

    seq_state_e      r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_bus_err;

    logic w_imem_req;
    logic w_dmem_req;
    logic w_dmem_we;
    logic w_ir_wen;
    logic w_pc_wen;
    logic w_rf_wen;
    logic w_cycle_en;

    // Handshake and write-enable decode. Everything is forced low while
    // rst is high so a pending request never completes in the reset cycle.
    always_comb begin
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_ir_wen   = 1'b0;
        w_pc_wen   = 1'b0;
        w_rf_wen   = 1'b0;
        if (!rst) begin
            case (r_state)
                SEQ_FETCH: begin
                    w_imem_req = 1'b1;
                    w_ir_wen   = imem_ready;
                end
                SEQ_MEM: begin
                    // Stores also raise mem_ren; mem_wen decides the direction.
                    w_dmem_req = 1'b1;
                    w_dmem_we  = mem_wen;
                    w_pc_wen   = dmem_ready & mem_wen;
                end
                SEQ_WB: begin
                    w_pc_wen = 1'b1;
                    w_rf_wen = reg_wen;
                end
                default: ;
            endcase
        end
    end

    // FSM plus handshake wait counter. The counter is cleared whenever a
    // requesting state is entered; ready in the final allowed cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEQ_FETCH;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                SEQ_FETCH: begin
                    if (imem_ready) begin
                        r_state <= SEQ_DECODE;
                    end else if (r_wait_cnt == WC_MAX) begin
                        r_state   <= SEQ_HALT;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                SEQ_DECODE: r_state <= SEQ_EXEC;
                SEQ_EXEC: begin
                    r_wait_cnt <= '0;
                    r_state    <= (mem_ren | mem_wen) ? SEQ_MEM : SEQ_WB;
                end
                SEQ_MEM: begin
                    if (dmem_ready) begin
                        r_wait_cnt <= '0;
                        r_state    <= mem_wen ? SEQ_FETCH : SEQ_WB;
                    end else if (r_wait_cnt == WC_MAX) begin
                        r_state   <= SEQ_HALT;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                SEQ_WB: begin
                    r_wait_cnt <= '0;
                    r_state    <= SEQ_FETCH;
                end
                SEQ_HALT: r_state <= SEQ_HALT;
                default: begin
                    // Corrupted state code: stop the core and flag it.
                    r_state   <= SEQ_HALT;
                    r_bus_err <= 1'b1;
                end
            endcase
        end
    end

    assign w_cycle_en = (r_state != SEQ_HALT);

    seq_perf_cnt #(
        .W (CNT_WIDTH)
    ) u_perf_cnt (
        .clk          (clk),
        .i_clr        (rst),
        .i_instret_en (w_pc_wen),
        .i_cycle_en   (w_cycle_en),
        .o_instret    (instret),
        .o_cycle      (cycle)
    );

    assign imem_req = w_imem_req;
    assign dmem_req = w_dmem_req;
    assign dmem_we  = w_dmem_we;
    assign ir_wen   = w_ir_wen;
    assign pc_wen   = w_pc_wen;
    assign rf_wen   = w_rf_wen;
    assign busy     = (r_state != SEQ_HALT);
    assign bus_err  = r_bus_err;
    assign state    = r_state;

endmodule
